i2c_control_unit: RTL and testbench
===================================

# i2c_control_unit

Sequencing controller for the I2C data unit: generates the quarter-bit timebase from `ClockFrequency`/`BaudRate`, drives SCL, and issues the data unit's control strobes (`WriteLoad`, `ReadorWrite`, `ShiftorHold`, `Select`, `StartStopAck`) for one complete single-byte I2C master transaction. A transaction is START, address byte, address ACK, one data byte (write or read), ACK/NACK, STOP. It sits between the host command interface and the data unit, which owns the shift register and the SDA pad.

## Interface
- `LENGTH`, 8, byte width; also the number of data-unit shifts per byte.
- `clock`  in  1  system clock, all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Go`  in  1  start request; sampled only in IDLE.
- `RW`  in  1  transaction direction latched with `Go` (0 = write data byte, 1 = read data byte).
- `BaudRate`  in  20  SCL bit rate in Hz.
- `ClockFrequency`  in  30  `clock` frequency in Hz; `4*BaudRate <= ClockFrequency` required.
- `SDAIn`  in  1  sampled SDA line level, used for slave ACK.
- `WriteLoad`  out  1  one-cycle pulse: data unit loads `SentData`.
- `ReadorWrite`  out  1  1 = data unit drives SDA, 0 = SDA released.
- `ShiftorHold`  out  1  one-cycle pulse: data unit shifts one bit (MSB first).
- `Select`  out  1  1 = shift-register bit on SDA, 0 = `StartStopAck` on SDA.
- `StartStopAck`  out  1  level driven on SDA when `Select`=0.
- `ByteSel`  out  1  external `SentData` mux: 0 = address byte, 1 = data byte.
- `SCL`  out  1  I2C clock.
- `Busy`  out  1  high from `Go` acceptance until `Done`.
- `Done`  out  1  one-cycle pulse at end of STOP.
- `AckError`  out  1  set if a slave ACK sampled high; cleared on next accepted `Go`.

## Operation
- Timebase: 31-bit accumulator adds `4*BaudRate` each clock; when sum >= `ClockFrequency`, subtract `ClockFrequency` and assert quarter tick `qt` for one cycle. Accumulator cleared in IDLE. Each bit = 4 ticks, quarters Q0..Q3.
- Bit shape: Q0,Q1 SCL low (SDA changes at Q0); Q2,Q3 SCL high; SDA sampled / `ShiftorHold` pulsed on the Q3 tick.
- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP.
- IDLE: `SCL`=1, `ReadorWrite`=1, `Select`=0, `StartStopAck`=1. `Go`=1 -> latch `RW`, clear `AckError`, `Busy`=1, go START.
- START (4 ticks): Q0,Q1 SDA=1, SCL=1; Q2 SDA=0 with SCL=1; Q3 SCL=0. On exit: `ByteSel`=0, `WriteLoad` pulse, bit counter=0 -> ADDR.
- ADDR: `ReadorWrite`=1, `Select`=1; `ShiftorHold` pulse on each Q3 tick; after 8th bit -> AACK.
- AACK: `ReadorWrite`=0; Q3 tick samples `SDAIn`; 1 sets `AckError` and goes to STOP (data byte skipped); 0 goes DATA. Entering DATA on write: `ByteSel`=1 and `WriteLoad` pulse; on read: no load.
- DATA write: as ADDR. DATA read: `ReadorWrite`=0, `ShiftorHold` on each Q3 tick (data unit captures SDA). After 8 bits -> DACK.
- DACK write: release, sample as AACK (error sets `AckError`, still -> STOP). DACK read: `ReadorWrite`=1, `Select`=0, `StartStopAck`=1 (NACK) -> STOP.
- STOP (4 ticks): Q0 SDA=0, SCL=0; Q1 SDA=0, SCL=1; Q2 SDA=1, SCL=1; Q3 hold. On Q3 tick: `Done` pulse, `Busy`=0, -> IDLE.

## Timing
- All outputs registered. Reset values: `WriteLoad`=0, `ReadorWrite`=1, `ShiftorHold`=0, `Select`=0, `StartStopAck`=1, `ByteSel`=0, `SCL`=1, `Busy`=0, `Done`=0, `AckError`=0; state IDLE, accumulator and bit counter 0.
- `Busy` rises the cycle after `Go` is sampled. `Go` while `Busy` ignored; `Go` held high through `Done` starts a new transaction the cycle after returning to IDLE.
- `WriteLoad` and `ShiftorHold` never assert in the same cycle; `WriteLoad` precedes the first Q0 of its byte.
- Full transaction = 80 ticks (4 + 36 + 36 + 4); NACK on address = 44 ticks.
- `Reset` mid-transaction: next edge forces reset values (SCL and SDA released high); no STOP generated.
- `BaudRate`/`ClockFrequency` must be stable while `Busy`; `BaudRate`=0 -> no ticks, FSM stalls in START (legal, recover by `Reset`).

## Test plan
- `ClockFrequency`=16, `BaudRate`=2, `Go`,`RW`=0, `SDAIn`=0 at ACK quarters -> tick every 2 clocks, 2 `WriteLoad` pulses, 16 `ShiftorHold` pulses, `Done` 160 clocks after `Busy` rise, `AckError`=0.
- Same, `RW`=1 -> 1 `WriteLoad`, 16 `ShiftorHold`, `ReadorWrite`=0 during the 8 data bits, `StartStopAck`=1 `Select`=0 in DACK.
- `SDAIn`=1 at AACK -> `AckError`=1, 8 `ShiftorHold` only, `Done` 88 clocks after `Busy`.
- START/STOP shape: SDA (from `Select`/`StartStopAck`) falls while `SCL`=1 in START, rises while `SCL`=1 in STOP; `SCL` period 8 clocks in bit states.
- `Reset` asserted in DATA bit 3 -> next edge all outputs at reset values, IDLE; subsequent `Go` runs a full transaction normally.
- `Go` pulsed while `Busy` -> ignored, single `Done`; `AckError` from prior NACK cleared on next accepted `Go`.

Source files
------------

// File: rtl/i2c_control_unit_if.sv
// Control strobes from the I2C sequencer to the data unit, plus the sampled SDA level coming back.
interface i2c_control_unit_if;
  logic WriteLoad;
  logic ReadorWrite;
  logic ShiftorHold;
  logic Select;
  logic StartStopAck;
  logic ByteSel;
  logic SCL;
  logic SDAIn;

  modport master (
    output WriteLoad, ReadorWrite, ShiftorHold, Select, StartStopAck, ByteSel, SCL,
    input  SDAIn
  );

  modport slave (
    input  WriteLoad, ReadorWrite, ShiftorHold, Select, StartStopAck, ByteSel, SCL,
    output SDAIn
  );
endinterface

// File: rtl/i2c_control_unit.sv
// Single-byte I2C master sequencer: quarter-bit timebase, SCL and data-unit strobes.
// Outputs are registered and reflect the state one clock after the tick that caused them; no backpressure.
module i2c_control_unit #(
  parameter int LENGTH = 8
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               Go,
  input  logic               RW,
  input  logic [19:0]        BaudRate,
  input  logic [29:0]        ClockFrequency,
  output logic               Busy,
  output logic               Done,
  output logic               AckError,
  i2c_control_unit_if.master dataUnit
);
  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(LENGTH - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;

  state_t        state, nextState;
  logic [1:0]    quarter, nextQuarter;
  logic [CW-1:0] bitCnt, nextBitCnt;
  logic          rwLatched, nextRw;
  logic [30:0]   acc, nextAcc, sum;
  logic          qt, lastQ;
  logic          loadNext, shiftNext, doneNext, busyNext, ackErrNext, byteSelNext;
  logic          sclNext, rowNext, selNext, ssaNext;

  always_comb begin
    sum = acc + {9'd0, BaudRate, 2'b00};
    qt  = (state != IDLE) && (sum >= {1'b0, ClockFrequency});
    if (state == IDLE)
      nextAcc = '0;
    else if (qt)
      nextAcc = sum - {1'b0, ClockFrequency};
    else
      nextAcc = sum;
  end

  always_comb begin
    nextState   = state;
    nextQuarter = qt ? quarter + 2'd1 : quarter;
    nextBitCnt  = bitCnt;
    nextRw      = rwLatched;
    loadNext    = 1'b0;
    shiftNext   = 1'b0;
    doneNext    = 1'b0;
    busyNext    = Busy;
    ackErrNext  = AckError;
    byteSelNext = dataUnit.ByteSel;
    lastQ       = qt && (quarter == 2'd3);
    case (state)
      IDLE: begin
        nextQuarter = 2'd0;
        if (Go) begin
          nextState  = START;
          nextRw     = RW;
          ackErrNext = 1'b0;
          busyNext   = 1'b1;
        end
      end
      START: if (lastQ) begin
        nextState   = ADDR;
        nextBitCnt  = '0;
        loadNext    = 1'b1;
        byteSelNext = 1'b0;
      end
      ADDR, DATA: if (lastQ) begin
        shiftNext = 1'b1;
        if (bitCnt == LAST_BIT)
          nextState = (state == ADDR) ? AACK : DACK;
        else
          nextBitCnt = bitCnt + 1'b1;
      end
      AACK: if (lastQ) begin
        // A NACK on the address skips the data byte entirely.
        if (dataUnit.SDAIn) begin
          ackErrNext = 1'b1;
          nextState  = STOP;
        end else begin
          nextState  = DATA;
          nextBitCnt = '0;
          if (!rwLatched) begin
            loadNext    = 1'b1;
            byteSelNext = 1'b1;
          end
        end
      end
      DACK: if (lastQ) begin
        if (!rwLatched && dataUnit.SDAIn)
          ackErrNext = 1'b1;
        nextState = STOP;
      end
      STOP: if (lastQ) begin
        nextState = IDLE;
        doneNext  = 1'b1;
        busyNext  = 1'b0;
      end
      default: nextState = IDLE;
    endcase
  end

  // Line levels are decoded from the upcoming state so they land in the same cycle as it.
  always_comb begin
    sclNext = 1'b1;
    rowNext = 1'b1;
    selNext = 1'b0;
    ssaNext = 1'b1;
    case (nextState)
      START: begin
        ssaNext = (nextQuarter < 2'd2);
        sclNext = (nextQuarter != 2'd3);
      end
      ADDR: begin
        selNext = 1'b1;
        sclNext = nextQuarter[1];
      end
      AACK: begin
        rowNext = 1'b0;
        sclNext = nextQuarter[1];
      end
      DATA: begin
        selNext = 1'b1;
        rowNext = !nextRw;
        sclNext = nextQuarter[1];
      end
      DACK: begin
        rowNext = nextRw;
        sclNext = nextQuarter[1];
      end
      STOP: begin
        ssaNext = nextQuarter[1];
        sclNext = (nextQuarter != 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state                 <= IDLE;
      quarter               <= 2'd0;
      bitCnt                <= '0;
      rwLatched             <= 1'b0;
      acc                   <= '0;
      Busy                  <= 1'b0;
      Done                  <= 1'b0;
      AckError              <= 1'b0;
      dataUnit.WriteLoad    <= 1'b0;
      dataUnit.ReadorWrite  <= 1'b1;
      dataUnit.ShiftorHold  <= 1'b0;
      dataUnit.Select       <= 1'b0;
      dataUnit.StartStopAck <= 1'b1;
      dataUnit.ByteSel      <= 1'b0;
      dataUnit.SCL          <= 1'b1;
    end else begin
      state                 <= nextState;
      quarter               <= nextQuarter;
      bitCnt                <= nextBitCnt;
      rwLatched             <= nextRw;
      acc                   <= nextAcc;
      Busy                  <= busyNext;
      Done                  <= doneNext;
      AckError              <= ackErrNext;
      dataUnit.WriteLoad    <= loadNext;
      dataUnit.ReadorWrite  <= rowNext;
      dataUnit.ShiftorHold  <= shiftNext;
      dataUnit.Select       <= selNext;
      dataUnit.StartStopAck <= ssaNext;
      dataUnit.ByteSel      <= byteSelNext;
      dataUnit.SCL          <= sclNext;
    end
  end
endmodule

// File: tb/tb_i2c_control_unit.sv
// Bench for i2c_control_unit: a quarter-index transaction model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_i2c_control_unit;
  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Go = 1'b0;
  logic        RW = 1'b0;
  logic [19:0] BaudRate = 20'd2;
  logic [29:0] ClockFrequency = 30'd16;
  logic        Busy, Done, AckError;

  i2c_control_unit_if bus();

  i2c_control_unit #(.LENGTH(8)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .RW(RW),
    .BaudRate(BaudRate), .ClockFrequency(ClockFrequency),
    .Busy(Busy), .Done(Done), .AckError(AckError),
    .dataUnit(bus.master)
  );

  always #5 clock = ~clock;

  // Model state: transaction progress measured in elapsed quarter ticks k since Go was accepted.
  bit     mValid = 0, mActive = 0, mRW = 0, mNack = 0, mAckErr = 0, mByteSel = 0;
  longint mN = 0, mB = 1, mCF = 1;
  int     kCur = -1;
  bit     eBusy = 0, eDone = 0, eLoad = 0, eShift = 0, eScl = 1, eRow = 1, eSel = 0, eSsa = 1;
  bit     planAddrAck = 0, planDataAck = 0;

  function automatic void levels(input longint k, input bit nack, input bit rw,
                                 output bit scl, output bit row, output bit sel, output bit ssa);
    longint q;
    scl = 1; row = 1; sel = 0; ssa = 1;
    if (k < 0) begin
      q = 0;
    end else if (k < 4) begin
      scl = (k != 3); ssa = (k < 2);
    end else if (k < 36) begin
      q = (k - 4) % 4; scl = (q >= 2); sel = 1;
    end else if (k < 40) begin
      q = k - 36; scl = (q >= 2); row = 0;
    end else if (!nack && k < 72) begin
      q = (k - 40) % 4; scl = (q >= 2); sel = 1; row = !rw;
    end else if (!nack && k < 76) begin
      q = k - 72; scl = (q >= 2); row = rw;
    end else begin
      q = nack ? k - 40 : k - 76; ssa = (q >= 2); scl = (q != 0);
    end
  endfunction

  always @(posedge clock) begin : model
    longint k, kp;
    mValid = 1;
    eLoad = 0; eShift = 0; eDone = 0;
    if (Reset) begin
      mActive = 0; mAckErr = 0; mByteSel = 0; eBusy = 0; kCur = -1;
      levels(-1, 0, 0, eScl, eRow, eSel, eSsa);
    end else if (!mActive) begin
      if (Go) begin
        mActive = 1; mN = 0; mRW = RW; mNack = 0; mAckErr = 0;
        mB = longint'(BaudRate); mCF = longint'(ClockFrequency);
        kCur = 0; eBusy = 1;
        levels(0, 0, mRW, eScl, eRow, eSel, eSsa);
      end else begin
        kCur = -1;
        levels(-1, 0, 0, eScl, eRow, eSel, eSsa);
      end
    end else begin
      mN++;
      kp = ((mN - 1) * 4 * mB) / mCF;
      k  = (mN * 4 * mB) / mCF;
      if (k != kp) begin
        if (kp == 39 && bus.SDAIn) begin mNack = 1; mAckErr = 1; end
        if (kp == 75 && !mRW && bus.SDAIn) mAckErr = 1;
        if ((kp >= 4 && kp < 36 && kp % 4 == 3) || (!mNack && kp >= 40 && kp < 72 && kp % 4 == 3)) eShift = 1;
        if (k == 4) begin eLoad = 1; mByteSel = 0; end
        if (k == 40 && !mNack && !mRW) begin eLoad = 1; mByteSel = 1; end
      end
      kCur = int'(k);
      if (k == (mNack ? 64'sd44 : 64'sd80)) begin
        mActive = 0; eBusy = 0; eDone = 1; kCur = -1;
        levels(-1, 0, 0, eScl, eRow, eSel, eSsa);
      end else begin
        levels(k, mNack, mRW, eScl, eRow, eSel, eSsa);
      end
    end
  end

  // Slave side of SDA: planned ACK level inside the ACK quarters, noise elsewhere.
  always @(negedge clock) begin
    if (kCur >= 36 && kCur < 40)      bus.SDAIn = planAddrAck;
    else if (kCur >= 72 && kCur < 76) bus.SDAIn = planDataAck;
    else                              bus.SDAIn = 1'($urandom);
  end

  int cyc = 0, loadCnt = 0, shiftCnt = 0, doneCnt = 0, busyRiseCyc = 0, doneCyc = 0;
  bit busyPrev = 0;
  always @(negedge clock) begin
    cyc++;
    if (bus.WriteLoad === 1'b1) loadCnt++;
    if (bus.ShiftorHold === 1'b1) shiftCnt++;
    if (Done === 1'b1) begin doneCnt++; doneCyc = cyc; end
    if (Busy === 1'b1 && !busyPrev) busyRiseCyc = cyc;
    busyPrev = (Busy === 1'b1);
  end

  string litName [0:63];
  int    litGot [0:63];
  int    litExp [0:63];
  int    litCount = 0, litDone = 0;
  bit    finishReq = 0;
  int    total = 0, bad = 0;

  task automatic chk(input string name, input logic got, input bit exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mValid) begin
      chk("Busy", Busy, eBusy);
      chk("Done", Done, eDone);
      chk("AckError", AckError, mAckErr);
      chk("ByteSel", bus.ByteSel, mByteSel);
      chk("SCL", bus.SCL, eScl);
      chk("ReadorWrite", bus.ReadorWrite, eRow);
      chk("WriteLoad", bus.WriteLoad, eLoad);
      chk("ShiftorHold", bus.ShiftorHold, eShift);
      if (eRow) begin
        chk("Select", bus.Select, eSel);
        chk("StartStopAck", bus.StartStopAck, eSsa);
      end
    end
    while (litDone < litCount) begin
      total++;
      if (litGot[litDone] != litExp[litDone]) begin
        bad++;
        $display("FAIL %s got=%0d want=%0d", litName[litDone], litGot[litDone], litExp[litDone]);
      end
      litDone++;
    end
    if (finishReq) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (cyc > 90000) begin
      $display("FAIL watchdog cycles=%0d limit=90000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic push(input string n, input int got, input int exp);
    if (litCount < 64) begin
      litName[litCount] = n;
      litGot[litCount]  = got;
      litExp[litCount]  = exp;
      litCount++;
    end
  endtask

  task automatic startTxn(input bit rw, input bit aAck, input bit dAck);
    planAddrAck = aAck;
    planDataAck = dAck;
    RW = rw;
    Go = 1;
    tick;
    Go = 0;
    RW = 1'($urandom);
  endtask

  task automatic waitIdle(input string n);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick;
      if (Busy === 1'b0) ok = 1;
    end
    if (!ok) push({n, "_timeout"}, 0, 1);
  endtask

  task automatic runTxn(input string n, input bit rw, input bit aAck, input bit dAck);
    startTxn(rw, aAck, dAck);
    waitIdle(n);
    tick;
  endtask

  initial begin
    int l0, s0, d0;
    repeat (3) tick;
    Reset = 0;
    push("rst_busy", int'(Busy), 0);
    push("rst_scl", int'(bus.SCL), 1);
    push("rst_row", int'(bus.ReadorWrite), 1);
    push("rst_ssa", int'(bus.StartStopAck), 1);
    tick;

    BaudRate = 20'd2; ClockFrequency = 30'd16;
    l0 = loadCnt; s0 = shiftCnt; d0 = doneCnt;
    runTxn("wr", 0, 0, 0);
    push("wr_loads", loadCnt - l0, 2);
    push("wr_shifts", shiftCnt - s0, 16);
    push("wr_latency", doneCyc - busyRiseCyc, 160);
    push("wr_ackerr", int'(AckError), 0);
    push("wr_dones", doneCnt - d0, 1);

    l0 = loadCnt; s0 = shiftCnt;
    runTxn("rd", 1, 0, 1);
    push("rd_loads", loadCnt - l0, 1);
    push("rd_shifts", shiftCnt - s0, 16);
    push("rd_ackerr", int'(AckError), 0);

    l0 = loadCnt; s0 = shiftCnt;
    runTxn("nack", 0, 1, 0);
    push("nack_loads", loadCnt - l0, 1);
    push("nack_shifts", shiftCnt - s0, 8);
    push("nack_latency", doneCyc - busyRiseCyc, 88);
    push("nack_ackerr", int'(AckError), 1);

    d0 = doneCnt;
    startTxn(1, 0, 0);
    push("go_clears_ackerr", int'(AckError), 0);
    repeat (20) tick;
    Go = 1;
    tick;
    Go = 0;
    waitIdle("gobusy");
    repeat (4) tick;
    push("gobusy_dones", doneCnt - d0, 1);

    startTxn(0, 0, 0);
    for (int i = 0; i < 1000 && kCur < 53; i++) tick;
    push("rst_reached_data3", int'(kCur >= 53), 1);
    Reset = 1;
    tick;
    push("midrst_busy", int'(Busy), 0);
    push("midrst_scl", int'(bus.SCL), 1);
    push("midrst_row", int'(bus.ReadorWrite), 1);
    Reset = 0;
    tick;
    l0 = loadCnt; s0 = shiftCnt; d0 = doneCnt;
    runTxn("postrst", 0, 0, 0);
    push("postrst_loads", loadCnt - l0, 2);
    push("postrst_shifts", shiftCnt - s0, 16);
    push("postrst_dones", doneCnt - d0, 1);

    d0 = doneCnt;
    planAddrAck = 0; planDataAck = 0; RW = 0;
    Go = 1;
    for (int i = 0; i < 2000 && (doneCnt - d0) < 2; i++) tick;
    Go = 0;
    repeat (10) tick;
    push("b2b_dones", doneCnt - d0, 2);
    push("b2b_idle", int'(Busy), 0);

    BaudRate = 20'd0;
    s0 = shiftCnt;
    startTxn(0, 0, 0);
    repeat (40) tick;
    push("baud0_busy", int'(Busy), 1);
    push("baud0_shifts", shiftCnt - s0, 0);
    Reset = 1;
    tick;
    Reset = 0;
    tick;

    for (int t = 0; t < 25; t++) begin
      bit rw, aAck, dAck;
      int b;
      b = int'($urandom_range(1, 6));
      BaudRate = 20'(b);
      ClockFrequency = 30'(4 * b + int'($urandom_range(0, 12 * b)));
      rw = 1'($urandom);
      aAck = ($urandom_range(0, 4) == 0);
      dAck = ($urandom_range(0, 3) == 0);
      d0 = doneCnt;
      tick;
      runTxn("rand", rw, aAck, dAck);
      push("rand_ackerr", int'(AckError), int'(aAck || (!rw && dAck)));
      push("rand_dones", doneCnt - d0, 1);
    end

    finishReq = 1;
  end
endmodule
